// File: rtl/morse_pkg.sv
// Shared encodings and constants for the Morse stream decoder.
package morse_pkg;
  typedef enum logic [1:0] {IDLE, MARK, SPACE, WORDWAIT} state_t;

  localparam logic [2:0] DASH_UNITS   = 3'd2;
  localparam logic [2:0] LETTER_UNITS = 3'd3;
  localparam logic [2:0] WORD_UNITS   = 3'd7;

  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
endpackage

// File: rtl/morse_lut.sv
// Combinational Morse code table: (length, pattern) -> ASCII, '?' when unknown.
module morse_lut
  import morse_pkg::*;
#(
  parameter int MAX_SYMBOLS = 6,
  parameter int LW          = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic [LW-1:0]          len,
  input  logic [MAX_SYMBOLS-1:0] pattern,
  output logic [7:0]             ascii
);
  logic [11:0] key;

  // key = {length nibble, pattern byte}; dot = 0, first symbol in the MSB of the used field
  always_comb begin
    key   = {4'(len), 8'(pattern)};
    ascii = ASCII_QMARK;
    case (key)
      12'h100: ascii = "E";  12'h101: ascii = "T";
      12'h200: ascii = "I";  12'h201: ascii = "A";
      12'h202: ascii = "N";  12'h203: ascii = "M";
      12'h300: ascii = "S";  12'h301: ascii = "U";
      12'h302: ascii = "R";  12'h303: ascii = "W";
      12'h304: ascii = "D";  12'h305: ascii = "K";
      12'h306: ascii = "G";  12'h307: ascii = "O";
      12'h400: ascii = "H";  12'h401: ascii = "V";
      12'h402: ascii = "F";  12'h404: ascii = "L";
      12'h406: ascii = "P";  12'h407: ascii = "J";
      12'h408: ascii = "B";  12'h409: ascii = "X";
      12'h40A: ascii = "C";  12'h40B: ascii = "Y";
      12'h40C: ascii = "Z";  12'h40D: ascii = "Q";
      12'h51F: ascii = "0";  12'h50F: ascii = "1";
      12'h507: ascii = "2";  12'h503: ascii = "3";
      12'h501: ascii = "4";  12'h500: ascii = "5";
      12'h510: ascii = "6";  12'h518: ascii = "7";
      12'h51C: ascii = "8";  12'h51E: ascii = "9";
      default: ascii = ASCII_QMARK;
    endcase
  end
endmodule

// File: rtl/register.sv
// Generic D register with synchronous active-high clear.
module register #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset) q <= '0;
    else       q <= d;
endmodule

// File: rtl/morse_stream_decoder.sv
// Single-key Morse decoder: sync + debounce, dot/dash timing, gap detection,
// ASCII out on a valid/ready stream with sticky overflow.
module morse_stream_decoder
  import morse_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int UNIT_CYCLES     = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int MAX_SYMBOLS     = 6,
  parameter int EMIT_SPACE      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       key_clean
);
  localparam int CW         = $clog2(UNIT_CYCLES + 1);
  localparam int DBW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int AW         = $clog2(ARM_CYCLES + 1);
  localparam int LW         = $clog2(MAX_SYMBOLS + 1);

  logic [SYNC_STAGES:0] sync_chain;
  logic                 key_s;

  assign sync_chain[0] = key_in;
  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    register #(.W(1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sync_chain[g]),
      .q     (sync_chain[g+1])
    );
  end
  assign key_s = sync_chain[SYNC_STAGES];

  logic [DBW-1:0] db_cnt;
  logic [AW-1:0]  arm_cnt;
  logic           armed, kc_d, rise, fall;

  // The synchroniser flushes to 0 on reset, so a held key looks released for
  // SYNC_STAGES cycles; arming needs a low longer than that plus the debounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_clean <= 1'b0;
      kc_d      <= 1'b0;
      db_cnt    <= '0;
      arm_cnt   <= '0;
      armed     <= 1'b0;
    end else begin
      kc_d <= key_clean;
      if (key_s != key_clean) begin
        if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
          key_clean <= key_s;
          db_cnt    <= '0;
        end else db_cnt <= db_cnt + DBW'(1);
      end else db_cnt <= '0;
      if (!armed && !key_s && !key_clean) begin
        if (arm_cnt == AW'(ARM_CYCLES - 1)) armed <= 1'b1;
        else arm_cnt <= arm_cnt + AW'(1);
      end else arm_cnt <= '0;
    end
  end

  assign rise = key_clean & ~kc_d;
  assign fall = ~key_clean & kc_d;

  logic [CW-1:0] cyc;
  logic [2:0]    units;

  always_ff @(posedge clk) begin
    if (reset || rise || fall) begin
      cyc   <= '0;
      units <= '0;
    end else if (cyc == CW'(UNIT_CYCLES - 1)) begin
      cyc <= '0;
      if (units != 3'd7) units <= units + 3'd1;
    end else cyc <= cyc + CW'(1);
  end

  state_t                 state;
  logic [MAX_SYMBOLS-1:0] sym;
  logic [LW-1:0]          len;
  logic                   sym_ovf;
  logic [7:0]             lut_char, emit_char;
  logic                   emit;

  morse_lut #(.MAX_SYMBOLS(MAX_SYMBOLS), .LW(LW)) u_lut (
    .len     (len),
    .pattern (sym),
    .ascii   (lut_char)
  );

  always_comb begin
    emit      = 1'b0;
    emit_char = sym_ovf ? ASCII_QMARK : lut_char;
    if (state == SPACE && !rise && units == LETTER_UNITS)
      emit = 1'b1;
    else if (state == WORDWAIT && !rise && units == WORD_UNITS && EMIT_SPACE != 0) begin
      emit      = 1'b1;
      emit_char = ASCII_SPACE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sym       <= '0;
      len       <= '0;
      sym_ovf   <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (emit) begin
        if (!out_valid || out_ready) begin
          out_data  <= emit_char;
          out_valid <= 1'b1;
        end else overflow <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;

      case (state)
        IDLE:     if (rise && armed) state <= MARK;
        MARK:     if (fall) begin
                    state <= SPACE;
                    if (len == LW'(MAX_SYMBOLS)) sym_ovf <= 1'b1;
                    else begin
                      sym <= {sym[MAX_SYMBOLS-2:0], units >= DASH_UNITS};
                      len <= len + LW'(1);
                    end
                  end
        SPACE:    if (rise) state <= MARK;
                  else if (units == LETTER_UNITS) begin
                    state   <= WORDWAIT;
                    sym     <= '0;
                    len     <= '0;
                    sym_ovf <= 1'b0;
                  end
        WORDWAIT: if (rise) state <= MARK;
                  else if (units == WORD_UNITS) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_morse_stream_decoder.sv
// Directed bench for morse_stream_decoder with small timing parameters.
module tb_morse_stream_decoder;
  import morse_pkg::*;

  logic       clk = 1'b0;
  logic       reset, key_in, out_ready;
  logic [7:0] out_data;
  logic       out_valid, overflow, key_clean;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  morse_stream_decoder #(
    .SYNC_STAGES(2), .UNIT_CYCLES(10), .DEBOUNCE_CYCLES(2),
    .MAX_SYMBOLS(6), .EMIT_SPACE(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .key_clean (key_clean)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int n);
    key_in = 1'b1;
    tick(n);
    key_in = 1'b0;
  endtask

  task automatic dot();
    press(8);
    tick(12);
  endtask

  task automatic dash();
    press(30);
    tick(12);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200 && out_valid !== 1'b1; i++) @(negedge clk);
  endtask

  // Waits for a character, checks it, and lets the handshake (out_ready=1) consume it.
  task automatic expect_char(input string tag, input logic [7:0] exp_c);
    wait_valid();
    chk({tag, "_valid"}, 8'(out_valid), 8'd1);
    chk(tag, out_data, exp_c);
    tick(1);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; key_in = 1'b0; out_ready = 1'b1;
    tick(3);
    chk("rst_valid", 8'(out_valid), 8'd0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_ovf", 8'(overflow), 8'd0);
    chk("rst_clean", 8'(key_clean), 8'd0);
    reset = 1'b0;
    tick(10);

    press(8);
    expect_char("e_letter", 8'h45);
    expect_char("e_space", 8'h20);

    dot(); press(30);
    expect_char("a_letter", 8'h41);
    expect_char("a_space", 8'h20);

    key_in = 1'b1; tick(1); key_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (key_clean !== 1'b0 || out_valid !== 1'b0) seen = 1'b1;
      tick(1);
    end
    chk("glitch_quiet", 8'(seen), 8'd0);

    out_ready = 1'b0;
    press(8);
    wait_valid();
    chk("bp_e_valid", 8'(out_valid), 8'd1);
    press(30);
    for (int i = 0; i < 200 && overflow !== 1'b1; i++) @(negedge clk);
    chk("bp_ovf", 8'(overflow), 8'd1);
    chk("bp_hold_valid", 8'(out_valid), 8'd1);
    chk("bp_hold_data", out_data, 8'h45);
    out_ready = 1'b1;
    tick(1);
    chk("bp_handshake", 8'(out_valid), 8'd0);
    expect_char("bp_space", 8'h20);
    chk("bp_ovf_sticky", 8'(overflow), 8'd1);

    repeat (7) dot();
    expect_char("long7", 8'h3F);
    expect_char("long7_space", 8'h20);

    repeat (6) dot();
    expect_char("unk6", 8'h3F);
    expect_char("unk6_space", 8'h20);

    repeat (5) dot();
    expect_char("five", 8'h35);
    expect_char("five_space", 8'h20);

    dash(); dash(); dot(); dash();
    expect_char("q_letter", 8'h51);
    expect_char("q_space", 8'h20);

    key_in = 1'b1;
    tick(15);
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(20);
    key_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick(1);
    end
    chk("mid_rst_quiet", 8'(seen), 8'd0);
    chk("mid_rst_state", 8'(dut.state), 8'(IDLE));
    chk("mid_rst_data", out_data, 8'h00);
    chk("mid_rst_ovf", 8'(overflow), 8'd0);
    chk("mid_rst_clean", 8'(key_clean), 8'd0);

    press(8);
    expect_char("post_rst_e", 8'h45);
    expect_char("post_rst_space", 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
